// File: rtl/coproc_stream_sram_writer.sv
// coproc_stream_sram_writer: packs a byte stream little-endian into 32-bit words and writes them into a single-port SRAM
// Ports: clk/reset (async, active-high); start latches base_addr and length_bytes;
//        s_data/s_valid/s_ready carry the byte stream in;
//        sram_* drive the SRAM slave (clken is held at 1 once out of reset);
//        busy/done/words_written report transfer status.
// Option: COPROC_STREAM_WRITER_CHECKSUM_EN adds checksum[15:0], the 16-bit sum of the bytes accepted in the current transfer.
module coproc_stream_sram_writer #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length_bytes,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic [3:0]        sram_byteenable,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [31:0]       sram_writedata,
    output logic              sram_clken,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_written
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);
    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
    state_t state;
    logic [LEN_W-1:0] remaining;
    logic [ADDR_W-1:0] addr;
    logic [1:0] idx;
    logic [3:0] mask;
    logic [31:0] pack;
    logic [31:0] pack_n;
    logic [3:0] mask_n;
    logic accept;
    assign accept = s_valid & s_ready;
    always_comb begin
        pack_n = pack | ({24'd0, s_data} << {idx, 3'b000});
        mask_n = mask | (4'b0001 << idx);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            remaining       <= '0;
            addr            <= '0;
            idx             <= '0;
            mask            <= '0;
            pack            <= '0;
            s_ready         <= 1'b0;
            sram_address    <= '0;
            sram_byteenable <= '0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_writedata  <= '0;
            sram_clken      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            words_written   <= '0;
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
            checksum        <= '0;
`endif
        end else begin
            sram_clken <= 1'b1;
            done       <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    addr          <= base_addr;
                    remaining     <= length_bytes;
                    words_written <= '0;
                    idx           <= '0;
                    mask          <= '0;
                    pack          <= '0;
                    busy          <= 1'b1;
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
                    checksum      <= '0;
`endif
                    state   <= (length_bytes == '0) ? DONE : FILL;
                    s_ready <= (length_bytes != '0);
                end
                FILL: if (accept) begin
                    pack      <= pack_n;
                    mask      <= mask_n;
                    idx       <= idx + 2'd1;
                    remaining <= remaining - 1'b1;
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
                    checksum  <= checksum + {8'd0, s_data};
`endif
                    // word is issued with the byte that fills lane 3 or ends the stream
                    if (idx == 2'd3 || remaining == LEN_W'(1)) begin
                        state           <= WRITE;
                        s_ready         <= 1'b0;
                        sram_chipselect <= 1'b1;
                        sram_write      <= 1'b1;
                        sram_address    <= addr;
                        sram_writedata  <= pack_n;
                        sram_byteenable <= mask_n;
                    end
                end
                WRITE: begin
                    sram_chipselect <= 1'b0;
                    sram_write      <= 1'b0;
                    sram_byteenable <= '0;
                    addr            <= addr + 1'b1;
                    words_written   <= words_written + 1'b1;
                    idx             <= '0;
                    mask            <= '0;
                    pack            <= '0;
                    state           <= (remaining == '0) ? DONE : FILL;
                    s_ready         <= (remaining != '0);
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coproc_stream_sram_writer.sv
// tb_coproc_stream_sram_writer: directed bench for coproc_stream_sram_writer
module tb_coproc_stream_sram_writer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [12:0] length_bytes;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  sram_address;
    logic [3:0]  sram_byteenable;
    logic        sram_chipselect;
    logic        sram_write;
    logic [31:0] sram_writedata;
    logic        sram_clken;
    logic        busy;
    logic        done;
    logic [10:0] words_written;
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
    logic [15:0] checksum;
`endif
    int passed = 0;
    int total = 0;
    int done_cnt = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0] wb[$];
    logic [7:0] bytes[8];

    coproc_stream_sram_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length_bytes(length_bytes), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .sram_address(sram_address), .sram_byteenable(sram_byteenable),
        .sram_chipselect(sram_chipselect), .sram_write(sram_write),
        .sram_writedata(sram_writedata), .sram_clken(sram_clken),
        .busy(busy), .done(done), .words_written(words_written)
`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset) begin
        if (sram_chipselect | sram_write) begin
            wa.push_back(32'(sram_address));
            wd.push_back(sram_writedata);
            wb.push_back(sram_byteenable);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_wr(input string tag, input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        check({tag, "_addr"}, (i < wa.size()) ? wa[i] : 32'hDEAD_BEEF, a);
        check({tag, "_data"}, (i < wd.size()) ? wd[i] : 32'hDEAD_BEEF, d);
        check({tag, "_be"}, (i < wb.size()) ? 32'(wb[i]) : 32'hDEAD_BEEF, 32'(be));
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        wb.delete();
        done_cnt = 0;
    endtask

    task automatic kick(input logic [9:0] a, input logic [12:0] n);
        base_addr = a;
        length_bytes = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n);
        int i = 0;
        int g = 0;
        logic acc;
        while (i < n && g < 200) begin
            s_data = bytes[i];
            s_valid = 1'b1;
            acc = s_ready;
            @(negedge clk);
            g++;
            if (acc) i++;
        end
        s_valid = 1'b0;
        if (i < n) check("stream_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        length_bytes = '0;
        s_data = '0;
        s_valid = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_cs", 32'(sram_chipselect), 0);
        check("rst_clken", 32'(sram_clken), 0);
        check("rst_ww", 32'(words_written), 0);
        repeat (2) @(negedge clk);
        check("rst_clken_held", 32'(sram_clken), 0);
        reset = 1'b0;
        @(negedge clk);
        check("clken_on", 32'(sram_clken), 1);
        check("idle_ready", 32'(s_ready), 0);

        // full words
        clear_log();
        for (int i = 0; i < 8; i++) bytes[i] = 8'h11 + 8'(i);
        kick(10'h010, 13'd8);
        stream(8);
        wait_done("t1");
        check("t1_ww", 32'(words_written), 2);
        check("t1_nwr", wa.size(), 2);
        check_wr("t1_w0", 0, 32'h010, 32'h14131211, 4'b1111);
        check_wr("t1_w1", 1, 32'h011, 32'h18171615, 4'b1111);
        @(negedge clk);
        check("t1_busy", 32'(busy), 0);
        check("t1_done_once", 32'(done_cnt), 1);

        // partial tail with address wrap
        clear_log();
        for (int i = 0; i < 6; i++) bytes[i] = 8'hA0 + 8'(i);
        kick(10'h3FF, 13'd6);
        stream(6);
        wait_done("t2");
        check("t2_ww", 32'(words_written), 2);
        check("t2_nwr", wa.size(), 2);
        check_wr("t2_w0", 0, 32'h3FF, 32'hA3A2A1A0, 4'b1111);
        check_wr("t2_w1", 1, 32'h000, 32'h0000A5A4, 4'b0011);
        @(negedge clk);

        // zero length
        clear_log();
        base_addr = 10'h055;
        length_bytes = 13'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t3_busy1", 32'(busy), 1);
        check("t3_done1", 32'(done), 0);
        @(negedge clk);
        check("t3_done2", 32'(done), 1);
        check("t3_busy2", 32'(busy), 0);
        check("t3_ww", 32'(words_written), 0);
        @(negedge clk);
        check("t3_done3", 32'(done), 0);
        check("t3_nwr", wa.size(), 0);

        // stall mid-word with an ignored start
        clear_log();
        bytes[0] = 8'h01; bytes[1] = 8'h02;
        kick(10'h100, 13'd4);
        stream(2);
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                base_addr = 10'h200;
                length_bytes = 13'd1;
                start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("t4_stall_nwr", wa.size(), 0);
        check("t4_stall_ready", 32'(s_ready), 1);
        check("t4_stall_busy", 32'(busy), 1);
        bytes[0] = 8'h03; bytes[1] = 8'h04;
        stream(2);
        wait_done("t4");
        check("t4_nwr", wa.size(), 1);
        check_wr("t4_w0", 0, 32'h100, 32'h04030201, 4'b1111);
        check("t4_ww", 32'(words_written), 1);
        @(negedge clk);

        // reset mid-transfer
        clear_log();
        for (int i = 0; i < 8; i++) bytes[i] = 8'h31 + 8'(i);
        kick(10'h020, 13'd8);
        stream(3);
        reset = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_ready", 32'(s_ready), 0);
        check("t5_cs", 32'(sram_chipselect), 0);
        check("t5_clken", 32'(sram_clken), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_nwr", wa.size(), 0);
        check("t5_ndone", 32'(done_cnt), 0);
        for (int i = 0; i < 4; i++) bytes[i] = 8'h41 + 8'(i);
        kick(10'h030, 13'd4);
        stream(4);
        wait_done("t5b");
        check("t5b_nwr", wa.size(), 1);
        check_wr("t5b_w0", 0, 32'h030, 32'h44434241, 4'b1111);
        check("t5b_ww", 32'(words_written), 1);
        @(negedge clk);

`ifdef COPROC_STREAM_WRITER_CHECKSUM_EN
        clear_log();
        bytes[0] = 8'hFF; bytes[1] = 8'hFF; bytes[2] = 8'h02;
        kick(10'h040, 13'd3);
        stream(3);
        wait_done("t6");
        check("t6_sum", 32'(checksum), 32'h0200);
        check_wr("t6_w0", 0, 32'h040, 32'h0002FFFF, 4'b0111);
        @(negedge clk);
        check("t6_sum_hold", 32'(checksum), 32'h0200);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
